// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable
// Word-organised instruction store, filled at run time through a valid/ready
// load stream driven by a small IDLE/LOAD/DONE loader FSM, and read by the
// fetch stage through a byte-addressed PC port with a registered 1-cycle read.
// The storage array carries no reset so loaded code survives a reset pulse.

module instruction_memory_loadable #(
  parameter int unsigned           ADDR_SIZE = 8,
  parameter int unsigned           INST_SIZE = 32,
  parameter int unsigned           PC_WIDTH  = 32,
  parameter logic [INST_SIZE-1:0]  NOP_INST  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // loader stream
  input  logic                  load_start,
  input  logic [ADDR_SIZE-1:0]  load_base,
  input  logic [ADDR_SIZE:0]    load_count,
  input  logic                  load_valid,
  input  logic [INST_SIZE-1:0]  load_data,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  // fetch port
  input  logic                  fetch_en,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [INST_SIZE-1:0]  instruction,
  output logic                  inst_valid,
  output logic                  misaligned,
  output logic                  out_of_range
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  // Burst length equal to the full depth is legal; anything above is rejected.
  localparam logic [ADDR_SIZE:0]   CNT_DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0]   CNT_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]   CNT_ZERO  = {(ADDR_SIZE+1){1'b0}};
  localparam logic [ADDR_SIZE-1:0] PTR_ONE   = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] PTR_ZERO  = {ADDR_SIZE{1'b0}};

  // Loader FSM encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Returns 1 when the byte address is not word aligned.
  function automatic logic is_misaligned(input logic [PC_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Returns 1 when any address bit above the word-index field is set.
  function automatic logic is_out_of_range(input logic [PC_WIDTH-1:0] addr);
    return (addr[PC_WIDTH-1:ADDR_SIZE+2] != {(PC_WIDTH-ADDR_SIZE-2){1'b0}});
  endfunction

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [INST_SIZE-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------
  // Loader state
  // ---------------------------------------------------------------------
  logic [1:0]           state_q,      state_d;
  logic [ADDR_SIZE-1:0] ptr_q,        ptr_d;
  logic [ADDR_SIZE:0]   remaining_q,  remaining_d;
  logic                 load_error_q, load_error_d;
  logic                 wr_en_s;

  // ---------------------------------------------------------------------
  // Fetch state
  // ---------------------------------------------------------------------
  logic [INST_SIZE-1:0] instruction_q,  instruction_d;
  logic                 inst_valid_q,   inst_valid_d;
  logic                 misaligned_q,   misaligned_d;
  logic                 out_of_range_q, out_of_range_d;

  logic [ADDR_SIZE-1:0] fetch_idx_s;
  logic                 fetch_mis_s;
  logic                 fetch_oor_s;
  logic [INST_SIZE-1:0] mem_rdata_s;

  // Loader next-state: burst acceptance, word counting and pointer wrap.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    load_error_d = 1'b0;
    wr_en_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (load_count > CNT_DEPTH) begin
            // Oversized burst: flag it and never touch the array.
            load_error_d = 1'b1;
            state_d      = ST_IDLE;
          end else if (load_count == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_LOAD;
            ptr_d       = load_base;
            remaining_d = load_count;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // load_ready is high for the whole of LOAD, so valid alone accepts.
        if (load_valid) begin
          wr_en_s     = 1'b1;
          ptr_d       = ptr_q + PTR_ONE;
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Unreachable encoding: fall back to a safe idle state.
        state_d     = ST_IDLE;
        ptr_d       = PTR_ZERO;
        remaining_d = CNT_ZERO;
      end
    endcase
  end

  // Loader registers; an async reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PTR_ZERO;
      remaining_q  <= CNT_ZERO;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      load_error_q <= load_error_d;
    end
  end

  // Array write port; deliberately unreset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[ptr_q] <= load_data;
    end
  end

  // Fetch address decode.
  always_comb begin
    fetch_idx_s = pc[ADDR_SIZE+1:2];
    fetch_mis_s = is_misaligned(pc);
    fetch_oor_s = is_out_of_range(pc);
    mem_rdata_s = mem[fetch_idx_s];
  end

  // Fetch result: hold when idle, NOP while loading, checked read otherwise.
  always_comb begin
    instruction_d  = instruction_q;
    inst_valid_d   = inst_valid_q;
    misaligned_d   = misaligned_q;
    out_of_range_d = out_of_range_q;
    if (fetch_en) begin
      if (state_q != ST_IDLE) begin
        // Stalled behind a load: no data, no fault flags.
        instruction_d  = NOP_INST;
        inst_valid_d   = 1'b0;
        misaligned_d   = 1'b0;
        out_of_range_d = 1'b0;
      end else if (fetch_mis_s || fetch_oor_s) begin
        instruction_d  = NOP_INST;
        inst_valid_d   = 1'b0;
        misaligned_d   = fetch_mis_s;
        out_of_range_d = fetch_oor_s;
      end else begin
        instruction_d  = mem_rdata_s;
        inst_valid_d   = 1'b1;
        misaligned_d   = 1'b0;
        out_of_range_d = 1'b0;
      end
    end else begin
      instruction_d  = instruction_q;
      inst_valid_d   = inst_valid_q;
      misaligned_d   = misaligned_q;
      out_of_range_d = out_of_range_q;
    end
  end

  // Fetch output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_q  <= NOP_INST;
      inst_valid_q   <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      instruction_q  <= instruction_d;
      inst_valid_q   <= inst_valid_d;
      misaligned_q   <= misaligned_d;
      out_of_range_q <= out_of_range_d;
    end
  end

  // Loader handshake decodes directly from the state register.
  assign load_ready   = (state_q == ST_LOAD);
  assign load_busy    = (state_q == ST_LOAD);
  assign load_done    = (state_q == ST_DONE);
  assign load_error   = load_error_q;

  assign instruction  = instruction_q;
  assign inst_valid   = inst_valid_q;
  assign misaligned   = misaligned_q;
  assign out_of_range = out_of_range_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Scoreboard bench for instruction_memory_loadable: the stimulus process
// pushes expected fetch results, loader events and status snapshots; a single
// monitor process pops and compares them when the DUT presents outputs.

module tb_instruction_memory_loadable;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0  = 32'h00007033;
  localparam logic [31:0] W1  = 32'h00100093;
  localparam logic [31:0] W2  = 32'h00200113;
  localparam logic [31:0] WA  = 32'h00208433;
  localparam logic [31:0] WB  = 32'h00308193;
  localparam logic [31:0] C0  = 32'h11111111;
  localparam logic [31:0] C1  = 32'h22222222;
  localparam logic [31:0] C2  = 32'h33333333;
  localparam logic [31:0] JNK = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  load_base;
  logic [8:0]  load_count;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready, load_busy, load_done, load_error;
  logic        fetch_en;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        inst_valid, misaligned, out_of_range;

  instruction_memory_loadable dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
    .fetch_en(fetch_en), .pc(pc), .instruction(instruction),
    .inst_valid(inst_valid), .misaligned(misaligned), .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] inst; logic v; logic m; logic o; } fexp_t;
  typedef struct packed { logic is_err; int cyc; } ev_t;
  typedef struct packed { logic busy; logic ready; logic done; logic err; logic chkf; fexp_t f; } st_t;

  fexp_t fq [$];
  ev_t   ev_q [$];
  st_t   sq [$];

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic fetch_seen = 1'b0;
  logic end_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) fetch_seen <= fetch_en && rst_n;

  task automatic cmp(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
  endtask

  // Monitor: all comparisons happen here on the falling edge.
  always @(negedge clk) begin
    fexp_t fe;
    ev_t   e;
    st_t   s;
    if (fetch_seen) begin
      if (fq.size() == 0) begin
        checks++;
        $display("FAIL fetch_unexpected: got inst %h with no expectation queued", instruction);
      end else begin
        fe = fq.pop_front();
        cmp("fetch", {instruction, inst_valid, misaligned, out_of_range}, fe);
      end
    end
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      e = ev_q.pop_front();
      checks++;
      $display("FAIL load_evt_missing: got nothing expected err=%0b at cycle %0d", e.is_err, e.cyc);
    end
    if (load_done || load_error) begin
      if (ev_q.size() == 0) begin
        checks++;
        $display("FAIL load_evt_unexpected: got done=%0b err=%0b at cycle %0d expected none",
                 load_done, load_error, cyc);
      end else begin
        e = ev_q.pop_front();
        cmp("load_evt", {1'b0, load_done, load_error, cyc}, {1'b0, ~e.is_err, e.is_err, e.cyc});
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      cmp("status", {31'd0, load_busy, load_ready, load_done, load_error},
                    {31'd0, s.busy, s.ready, s.done, s.err});
      if (s.chkf) cmp("fetch_out", {instruction, inst_valid, misaligned, out_of_range}, s.f);
    end
    if (end_req) begin
      cmp("fetch_q_empty", 35'(fq.size()), 35'd0);
      cmp("event_q_empty", 35'(ev_q.size()), 35'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_stat(input logic b, input logic r, input logic d, input logic er);
    st_t s;
    s = '{busy: b, ready: r, done: d, err: er, chkf: 1'b0, f: '0};
    sq.push_back(s);
  endtask

  task automatic exp_stat_f(input logic b, input logic r, input logic d, input logic er,
                            input logic [31:0] i, input logic v, input logic m, input logic o);
    st_t s;
    s = '{busy: b, ready: r, done: d, err: er, chkf: 1'b1, f: '{inst: i, v: v, m: m, o: o}};
    sq.push_back(s);
  endtask

  task automatic push_ev(input logic is_err, input int at);
    ev_t e;
    e = '{is_err: is_err, cyc: at};
    ev_q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] i,
                       input logic v, input logic m, input logic o);
    fexp_t fe;
    fe = '{inst: i, v: v, m: m, o: o};
    fq.push_back(fe);
    fetch_en = 1'b1;
    pc = addr;
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic start_burst(input logic [7:0] base, input logic [8:0] cnt);
    load_base = base;
    load_count = cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 1'b0; load_base = 8'd0; load_count = 9'd0;
    load_valid = 1'b0; load_data = 32'd0;
    fetch_en = 1'b0; pc = 32'd0;
    repeat (2) tick();
    exp_stat_f(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Three-word burst with a valid gap; fetch during LOAD stalls.
    start_burst(8'd0, 9'd3);
    exp_stat(1'b1, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b1; load_data = W0; tick();
    load_valid = 1'b0;
    fetch(32'h0, NOP, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b1; load_data = W1; tick();
    load_data = W2; push_ev(1'b0, cyc + 1); tick();
    load_valid = 1'b0;
    exp_stat(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    exp_stat(1'b0, 1'b0, 1'b0, 1'b0);
    fetch(32'h4, W1, 1'b1, 1'b0, 1'b0);
    fetch(32'h0, W0, 1'b1, 1'b0, 1'b0);
    fetch(32'h8, W2, 1'b1, 1'b0, 1'b0);
    // fetch_en low: outputs hold even though pc moves.
    pc = 32'h4; tick(); tick();
    exp_stat_f(1'b0, 1'b0, 1'b0, 1'b0, W2, 1'b1, 1'b0, 1'b0);
    tick();

    // Pointer wrap from the last word to word 0.
    start_burst(8'd255, 9'd2);
    load_valid = 1'b1; load_data = WA; tick();
    load_data = WB; push_ev(1'b0, cyc + 1); tick();
    load_valid = 1'b0; tick();
    fetch(32'h3FC, WA, 1'b1, 1'b0, 1'b0);
    fetch(32'h0,   WB, 1'b1, 1'b0, 1'b0);

    // Alignment and range faults.
    fetch(32'h6,   NOP, 1'b0, 1'b1, 1'b0);
    fetch(32'h400, NOP, 1'b0, 1'b0, 1'b1);
    fetch(32'h402, NOP, 1'b0, 1'b1, 1'b1);

    // Oversized burst rejected; junk on the stream must not land.
    load_valid = 1'b1; load_data = JNK;
    push_ev(1'b1, cyc + 1);
    start_burst(8'd0, 9'd257);
    exp_stat(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    exp_stat(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    load_valid = 1'b0;
    fetch(32'h3FC, WA, 1'b1, 1'b0, 1'b0);
    fetch(32'h0,   WB, 1'b1, 1'b0, 1'b0);
    fetch(32'h4,   W1, 1'b1, 1'b0, 1'b0);

    // Zero-length burst completes without writes.
    load_valid = 1'b1; load_data = JNK;
    push_ev(1'b0, cyc + 1);
    start_burst(8'd0, 9'd0);
    exp_stat(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    load_valid = 1'b0;
    exp_stat(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    fetch(32'h0,   WB, 1'b1, 1'b0, 1'b0);
    fetch(32'h3FC, WA, 1'b1, 1'b0, 1'b0);

    // Reset after two of four words: burst aborted, no done pulse.
    start_burst(8'd0, 9'd4);
    load_valid = 1'b1; load_data = C0; tick();
    load_data = C1; tick();
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_stat_f(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    load_valid = 1'b1; load_data = C2; tick();
    load_valid = 1'b0;
    exp_stat(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    fetch(32'h4, C1, 1'b1, 1'b0, 1'b0);
    fetch(32'h8, W2, 1'b1, 1'b0, 1'b0);
    fetch(32'h0, C0, 1'b1, 1'b0, 1'b0);

    tick(); tick();
    end_req = 1'b1;
    tick(); tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
